// File: rtl/keysw_mmio_dev.sv
// Memory-mapped KEY/SW input peripheral: synchronises and debounces the raw inputs, latches them
// into data registers and reports sticky ready/overrun status with an interrupt enable per device.
module keysw_mmio_dev #(
    parameter int unsigned           DBITS     = 32,
    parameter logic [DBITS-1:0]      ADDRKDATA = 32'hFFFFF080,
    parameter logic [DBITS-1:0]      ADDRKCTRL = 32'hFFFFF084,
    parameter logic [DBITS-1:0]      ADDRSDATA = 32'hFFFFF090,
    parameter logic [DBITS-1:0]      ADDRSCTRL = 32'hFFFFF094,
    parameter int unsigned           DEBOUNCE  = 500000,
    parameter int unsigned           CNTBITS   = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DBITS-1:0] abus,
    input  logic [DBITS-1:0] wrdata,
    input  logic             we,
    input  logic             re,
    output logic [DBITS-1:0] rddata,
    output logic             selected,
    input  logic [3:0]       KEY,
    input  logic [9:0]       SW,
    output logic             intr
);

    localparam logic [CNTBITS-1:0] CntMax = CNTBITS'(DEBOUNCE - 1);

    logic [3:0]         k_s1_q, k_s2_q, kdeb_q;
    logic [9:0]         s_s1_q, s_s2_q, sdeb_q;
    logic [CNTBITS-1:0] kcnt_q, scnt_q;
    logic               krdy_q, krdy_d, kov_q, kov_d, kie_q, kie_d;
    logic               srdy_q, srdy_d, sov_q, sov_d, sie_q, sie_d;
    logic               intr_q;
    logic               kset, sset;
    logic               hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;
    logic               kctrl_wr, sctrl_wr, krdy_clr, srdy_clr, kov_clr, sov_clr;
    logic               unused_wrdata;

    assign unused_wrdata = ^{wrdata[DBITS-1:9], wrdata[7:3], wrdata[1]};

    // A value is accepted once the synchronised input has held a new value for DEBOUNCE cycles.
    assign kset = (k_s1_q == k_s2_q) && (k_s2_q != kdeb_q) && (kcnt_q == CntMax);
    assign sset = (s_s1_q == s_s2_q) && (s_s2_q != sdeb_q) && (scnt_q == CntMax);

    // KEY is active-low; keep it inverted so 1 means pressed and the released state is 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            k_s1_q <= '0;
            k_s2_q <= '0;
            kdeb_q <= '0;
            kcnt_q <= '0;
        end else begin
            k_s1_q <= ~KEY;
            k_s2_q <= k_s1_q;
            if (k_s2_q == kdeb_q || k_s1_q != k_s2_q) begin
                kcnt_q <= '0;
            end else if (kcnt_q == CntMax) begin
                kdeb_q <= k_s2_q;
                kcnt_q <= '0;
            end else begin
                kcnt_q <= kcnt_q + CNTBITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s_s1_q <= '0;
            s_s2_q <= '0;
            sdeb_q <= '0;
            scnt_q <= '0;
        end else begin
            s_s1_q <= SW;
            s_s2_q <= s_s1_q;
            if (s_s2_q == sdeb_q || s_s1_q != s_s2_q) begin
                scnt_q <= '0;
            end else if (scnt_q == CntMax) begin
                sdeb_q <= s_s2_q;
                scnt_q <= '0;
            end else begin
                scnt_q <= scnt_q + CNTBITS'(1);
            end
        end
    end

    assign hit_kdata = (abus == ADDRKDATA);
    assign hit_kctrl = (abus == ADDRKCTRL);
    assign hit_sdata = (abus == ADDRSDATA);
    assign hit_sctrl = (abus == ADDRSCTRL);
    assign selected  = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;

    assign kctrl_wr = we & hit_kctrl;
    assign sctrl_wr = we & hit_sctrl;
    assign krdy_clr = (re & hit_kdata) | (kctrl_wr & ~wrdata[0]);
    assign srdy_clr = (re & hit_sdata) | (sctrl_wr & ~wrdata[0]);
    assign kov_clr  = kctrl_wr & ~wrdata[2];
    assign sov_clr  = sctrl_wr & ~wrdata[2];

    // Set events win over clears; overrun only when unread data is about to be overwritten.
    always_comb begin
        krdy_d = krdy_q;
        kov_d  = kov_q;
        kie_d  = kctrl_wr ? wrdata[8] : kie_q;
        if (kset)          krdy_d = 1'b1;
        else if (krdy_clr) krdy_d = 1'b0;
        if (kset && krdy_q && !krdy_clr) kov_d = 1'b1;
        else if (kov_clr)                kov_d = 1'b0;

        srdy_d = srdy_q;
        sov_d  = sov_q;
        sie_d  = sctrl_wr ? wrdata[8] : sie_q;
        if (sset)          srdy_d = 1'b1;
        else if (srdy_clr) srdy_d = 1'b0;
        if (sset && srdy_q && !srdy_clr) sov_d = 1'b1;
        else if (sov_clr)                sov_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            krdy_q <= 1'b0;
            kov_q  <= 1'b0;
            kie_q  <= 1'b0;
            srdy_q <= 1'b0;
            sov_q  <= 1'b0;
            sie_q  <= 1'b0;
            intr_q <= 1'b0;
        end else begin
            krdy_q <= krdy_d;
            kov_q  <= kov_d;
            kie_q  <= kie_d;
            srdy_q <= srdy_d;
            sov_q  <= sov_d;
            sie_q  <= sie_d;
            intr_q <= (krdy_d & kie_d) | (srdy_d & sie_d);
        end
    end

    assign intr = intr_q;

    always_comb begin
        rddata = '0;
        if (hit_kdata) begin
            rddata[3:0] = kdeb_q;
        end else if (hit_kctrl) begin
            rddata[8] = kie_q;
            rddata[2] = kov_q;
            rddata[0] = krdy_q;
        end else if (hit_sdata) begin
            rddata[9:0] = sdeb_q;
        end else if (hit_sctrl) begin
            rddata[8] = sie_q;
            rddata[2] = sov_q;
            rddata[0] = srdy_q;
        end
    end

endmodule

// File: tb/tb_keysw_mmio_dev.sv
// Randomised self-checking bench for keysw_mmio_dev against a run-length debounce model.
module tb_keysw_mmio_dev;

    localparam int unsigned D = 4;
    localparam logic [31:0] KDATA = 32'hFFFFF080;
    localparam logic [31:0] KCTRL = 32'hFFFFF084;
    localparam logic [31:0] SDATA = 32'hFFFFF090;
    localparam logic [31:0] SCTRL = 32'hFFFFF094;
    localparam logic [31:0] UNMAP = 32'hFFFFF0A0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] abus = '0, wrdata = '0, rddata;
    logic        we = 1'b0, re = 1'b0, selected, intr;
    logic [3:0]  key_in = 4'hF;
    logic [9:0]  sw_in = '0;

    int vecs = 0;
    int miss = 0;

    // Model: a value is accepted once the last D+1 sampled raw values agree and differ from deb.
    logic [3:0] m_klast, m_kdeb;
    logic [9:0] m_slast, m_sdeb;
    int         m_krun, m_srun;
    logic       m_krdy, m_kov, m_kie, m_srdy, m_sov, m_sie, m_intr;

    keysw_mmio_dev #(.DEBOUNCE(D)) dut (
        .clk(clk), .reset(reset), .abus(abus), .wrdata(wrdata), .we(we), .re(re),
        .rddata(rddata), .selected(selected), .KEY(key_in), .SW(sw_in), .intr(intr)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        logic kset, sset, kw, sw, kclr, sclr;
        if (reset) begin
            m_klast = '0; m_kdeb = '0; m_krun = 1000;
            m_slast = '0; m_sdeb = '0; m_srun = 1000;
            {m_krdy, m_kov, m_kie, m_srdy, m_sov, m_sie, m_intr} = '0;
        end else begin
            kset = (m_krun >= D + 1) && (m_klast != m_kdeb);
            sset = (m_srun >= D + 1) && (m_slast != m_sdeb);
            if (kset) m_kdeb = m_klast;
            if (sset) m_sdeb = m_slast;
            if (~key_in == m_klast) m_krun = (m_krun < 1000) ? m_krun + 1 : m_krun;
            else begin m_klast = ~key_in; m_krun = 1; end
            if (sw_in == m_slast) m_srun = (m_srun < 1000) ? m_srun + 1 : m_srun;
            else begin m_slast = sw_in; m_srun = 1; end
            kw = we && abus == KCTRL;
            sw = we && abus == SCTRL;
            kclr = (re && abus == KDATA) || (kw && !wrdata[0]);
            sclr = (re && abus == SDATA) || (sw && !wrdata[0]);
            if (kset && m_krdy && !kclr) m_kov = 1'b1;
            else if (kw && !wrdata[2])   m_kov = 1'b0;
            if (sset && m_srdy && !sclr) m_sov = 1'b1;
            else if (sw && !wrdata[2])   m_sov = 1'b0;
            m_krdy = kset ? 1'b1 : (kclr ? 1'b0 : m_krdy);
            m_srdy = sset ? 1'b1 : (sclr ? 1'b0 : m_srdy);
            if (kw) m_kie = wrdata[8];
            if (sw) m_sie = wrdata[8];
            m_intr = (m_krdy & m_kie) | (m_srdy & m_sie);
        end
    endtask

    function automatic logic [31:0] m_read(input logic [31:0] a);
        case (a)
            KDATA:   return {28'b0, m_kdeb};
            KCTRL:   return {23'b0, m_kie, 5'b0, m_kov, 1'b0, m_krdy};
            SDATA:   return {22'b0, m_sdeb};
            SCTRL:   return {23'b0, m_sie, 5'b0, m_sov, 1'b0, m_srdy};
            default: return 32'h0;
        endcase
    endfunction

    task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic w,
                        input logic r);
        abus = a; wrdata = wd; we = w; re = r;
        @(posedge clk);
        model_edge();
        #1;
        we = 1'b0; re = 1'b0;
    endtask

    task automatic peek(input logic [31:0] a);
        abus = a; we = 1'b0; re = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; key_in = 4'hF; sw_in = '0;
        step(UNMAP, '0, 1'b0, 1'b0);
        step(UNMAP, '0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] addrs [4] = '{KDATA, KCTRL, SDATA, SCTRL};
        do_reset();
        foreach (addrs[i]) begin
            peek(addrs[i]);
            vecs++;
            if (rddata !== 32'h0 || selected !== 1'b1) begin
                miss++;
                $display("FAIL reset_reg[%0d] got %h/%b exp 0/1", i, rddata, selected);
            end
        end
        vecs++;
        if (intr !== 1'b0) begin miss++; $display("FAIL reset_intr got %b exp 0", intr); end
    endtask

    task automatic test_sw_latency();
        logic [31:0] exp;
        do_reset();
        sw_in = 10'h2A5;
        for (int e = 1; e <= 8; e++) begin
            step(UNMAP, '0, 1'b0, 1'b0);
            peek(SDATA);
            exp = (e < 6) ? 32'h0 : 32'h2A5;
            vecs++;
            if (rddata !== exp) begin
                miss++;
                $display("FAIL sw_latency edge %0d got %h exp %h", e, rddata, exp);
            end
        end
        peek(SCTRL);
        vecs++;
        if (rddata !== 32'h1) begin miss++; $display("FAIL sw_sctrl got %h exp 1", rddata); end
    endtask

    task automatic test_key_read_clear();
        key_in = 4'hE;
        for (int i = 0; i < 8; i++) step(UNMAP, '0, 1'b0, 1'b0);
        peek(KDATA);
        vecs++;
        if (rddata !== 32'h1) begin miss++; $display("FAIL key_data got %h exp 1", rddata); end
        step(KDATA, '0, 1'b0, 1'b1);
        peek(KCTRL);
        vecs++;
        if (rddata !== 32'h0) begin miss++; $display("FAIL key_rdclr got %h exp 0", rddata); end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            key_in = (i >= 2 && i < 5) ? 4'hB : 4'hF;
            step(UNMAP, '0, 1'b0, 1'b0);
            peek(KDATA);
            vecs++;
            if (rddata !== 32'h0) begin
                miss++; $display("FAIL glitch_data cyc %0d got %h exp 0", i, rddata);
            end
        end
        peek(KCTRL);
        vecs++;
        if (rddata !== 32'h0) begin miss++; $display("FAIL glitch_ctrl got %h exp 0", rddata); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        key_in = 4'hE;
        for (int i = 0; i < 4; i++) step(UNMAP, '0, 1'b0, 1'b0);
        reset = 1'b1;
        step(UNMAP, '0, 1'b0, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(UNMAP, '0, 1'b0, 1'b0);
            peek(KCTRL);
            vecs++;
            if (rddata !== 32'h0) begin
                miss++; $display("FAIL reset_mid cyc %0d got %h exp 0", i, rddata);
            end
        end
    endtask

    task automatic test_overrun();
        do_reset();
        sw_in = 10'h001;
        for (int i = 0; i < 8; i++) step(UNMAP, '0, 1'b0, 1'b0);
        sw_in = 10'h002;
        for (int i = 0; i < 8; i++) step(UNMAP, '0, 1'b0, 1'b0);
        peek(SCTRL);
        vecs++;
        if (rddata !== 32'h5) begin miss++; $display("FAIL overrun_set got %h exp 5", rddata); end
        step(SCTRL, 32'h0, 1'b1, 1'b0);
        peek(SCTRL);
        vecs++;
        if (rddata !== 32'h0) begin miss++; $display("FAIL overrun_clr got %h exp 0", rddata); end
    endtask

    task automatic test_intr();
        int rise = -1;
        do_reset();
        step(KCTRL, 32'h100, 1'b1, 1'b0);
        key_in = 4'hE;
        for (int e = 1; e <= 10; e++) begin
            step(UNMAP, '0, 1'b0, 1'b0);
            if (intr === 1'b1 && rise < 0) rise = e;
        end
        vecs++;
        if (rise != 6) begin miss++; $display("FAIL intr_rise edge got %0d exp 6", rise); end
        step(KDATA, '0, 1'b0, 1'b1);
        vecs++;
        if (intr !== 1'b0) begin miss++; $display("FAIL intr_clear got %b exp 0", intr); end
    endtask

    task automatic test_collision();
        do_reset();
        key_in = 4'hE;
        for (int i = 0; i < 8; i++) step(UNMAP, '0, 1'b0, 1'b0);
        key_in = 4'hF;
        for (int i = 0; i < 5; i++) step(UNMAP, '0, 1'b0, 1'b0);
        step(KDATA, '0, 1'b0, 1'b1);
        peek(KCTRL);
        vecs++;
        if (rddata !== 32'h1) begin miss++; $display("FAIL collide_ctrl got %h exp 1", rddata); end
        peek(KDATA);
        vecs++;
        if (rddata !== 32'h0) begin miss++; $display("FAIL collide_data got %h exp 0", rddata); end
        peek(UNMAP);
        vecs++;
        if (rddata !== 32'h0 || selected !== 1'b0) begin
            miss++; $display("FAIL unmapped got %h/%b exp 0/0", rddata, selected);
        end
    endtask

    task automatic test_random();
        logic [31:0] pool [6];
        logic [31:0] a;
        pool = '{KDATA, KCTRL, SDATA, SCTRL, UNMAP, 32'h0};
        do_reset();
        for (int i = 0; i < 600; i++) begin
            pool[5] = $urandom;
            if ($urandom_range(5) == 0) key_in = 4'($urandom);
            if ($urandom_range(5) == 0) sw_in = 10'($urandom);
            reset = ($urandom_range(99) == 0);
            step(pool[$urandom_range(5)], $urandom, $urandom_range(7) == 0,
                 $urandom_range(3) == 0);
            reset = 1'b0;
            vecs++;
            if (intr !== m_intr) begin
                miss++; $display("FAIL rand_intr cyc %0d got %b exp %b", i, intr, m_intr);
            end
            a = pool[$urandom_range(5)];
            peek(a);
            vecs++;
            if (rddata !== m_read(a) || selected !== (a inside {KDATA, KCTRL, SDATA, SCTRL})) begin
                miss++;
                $display("FAIL rand_read cyc %0d addr %h got %h/%b exp %h", i, a, rddata,
                         selected, m_read(a));
            end
        end
    endtask

    initial begin
        test_reset();
        test_sw_latency();
        test_key_read_clear();
        test_glitch();
        test_reset_mid();
        test_overrun();
        test_intr();
        test_collision();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/keysw_mmio_dev.md
Name: keysw_mmio_dev

Overview:
- Memory-mapped input peripheral. It answers processor loads and stores on the data-memory bus at the KEY/SW addresses.
- It synchronises and debounces the KEY buttons and SW switches, latches debounced values into data registers, and keeps per-device sticky ready/overrun status bits plus an interrupt-enable bit.
- It replaces the bare combinational KEY/SW bus taps with a proper status/control register responder that can raise an interrupt.

Parameters:
- DBITS, 32, bus data and address width.
- ADDRKDATA, 32'hFFFFF080, KEY data register (read-only).
- ADDRKCTRL, 32'hFFFFF084, KEY control/status register.
- ADDRSDATA, 32'hFFFFF090, SW data register (read-only).
- ADDRSCTRL, 32'hFFFFF094, SW control/status register.
- DEBOUNCE, 500000, consecutive stable cycles required to accept an input change (>=1).
- CNTBITS, 20, debounce counter width (2^CNTBITS > DEBOUNCE).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- abus  in  DBITS  bus address (memaddr in M stage).
- wrdata  in  DBITS  store data.
- we  in  1  store strobe, valid for one cycle.
- re  in  1  load strobe, valid for one cycle.
- rddata  out  DBITS  load data; combinational from abus.
- selected  out  1  abus matches one of the four addresses.
- KEY  in  4  raw buttons, active-low.
- SW  in  10  raw switches, active-high.
- intr  out  1  interrupt request.

Behaviour:
- Reset (synchronous, at the clk edge with reset=1):
  - Sync flops are loaded with the released state (KEY=4'hF, SW=0).
  - Debounced kdeb and sdeb = 0; counters = 0.
  - All ready, overrun and IE bits = 0.
  - Outputs: intr=0. rddata stays combinational; selected=0 for unmapped addresses.
- Input path, per device (KEY uses ~KEY, so pressed=1):
  - Two-flop synchroniser s1 -> s2.
  - At each edge, if s2==deb or s1!=s2: cnt<=0.
  - Else if cnt==DEBOUNCE-1: deb<=s2, cnt<=0, and the ready-set event fires.
  - Else: cnt<=cnt+1.
  - Latency: a raw change stable from edge 0 appears in deb after edge DEBOUNCE+2.
  - A pulse shorter than DEBOUNCE cycles leaves deb unchanged.
- Register map:
  - KDATA read = {28'b0, kdeb}.
  - SDATA read = {22'b0, sdeb}.
  - xCTRL read = {23'b0, ie[8], 5'b0, overrun[2], 1'b0, ready[0]}.
  - Unmapped address: rddata=0, selected=0.
- Read side effect: an edge with re=1 and abus==xDATA clears that device's ready bit.
- Control writes: an edge with we=1 and abus==xCTRL does the following.
  - ie <= wrdata[8].
  - wrdata[0]=0 clears ready; 1 is ignored.
  - wrdata[2]=0 clears overrun; 1 is ignored.
- Writes to xDATA or to unmapped addresses are ignored.
- Set/clear priority (same edge):
  - A set event beats any read-clear or write-clear, so ready=1 after that edge.
  - overrun is set when a set event occurs while ready was 1 and is not being cleared that edge.
  - A set event coinciding with an overrun write-clear leaves overrun set if that set condition holds.
- re and we together on the same address: apply both effects.
- intr = (kready & kie) | (sready & sie). It is registered from the bit states, so it follows those bits with zero extra latency after the edge that changes them.
- Reset asserted mid-debounce: the count is discarded and no ready event fires.

Test Plan:
- DEBOUNCE=4, reset, SW=0 -> SW=10'h2A5 held from edge 0:
  - SDATA reads 0 through edge 5 and 32'h2A5 after edge 6.
  - SCTRL reads 32'h1.
- KEY=4'hE held stable, then load KDATA:
  - KDATA reads 32'h1.
  - After the load edge, KCTRL reads 32'h0.
- KEY glitch 4'hF->4'hB for 3 cycles with DEBOUNCE=4 -> kdeb stays 0, KCTRL stays 0.
- Two accepted SW changes with no intervening SDATA read -> SCTRL reads 32'h5. Store 0 to SCTRL -> SCTRL reads 32'h0.
- Store 32'h100 to KCTRL, then a debounced key press -> intr=1 after the ready edge. Load KDATA -> intr=0 next cycle.
- Load of KDATA on the same edge as a new key acceptance -> ready remains 1 and overrun stays 0. Separately, unmapped abus=32'hFFFFF0A0 -> rddata=0, selected=0.
